mem_bus_sequencer: RTL

- Upstream master of the LC-3 memory/IO subsystem.
- Converts single-word read/write requests from the CPU datapath into the subsystem's bus protocol: LD_MAR, LD_MDR, MIO_EN, R_W and GateMDR over the shared 16-bit BUS. It then waits for the R ready handshake.
- Returns the read data or a write-done completion to the datapath through a valid/ready response channel.
- Exactly one access is outstanding at a time.

---
 rtl/lc3_bus_pkg.sv | 25 ++
 rtl/mem_wait_timer.sv | 44 ++++
 rtl/mem_bus_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lc3_bus_pkg.sv
// -----------------------------------------------------------------------------
// lc3_bus_pkg
// Shared definitions for the LC-3 memory/IO bus master:
//   - seq_state_e           : sequencer FSM states
//   - ACCESS_WRITE/READ     : encodings driven onto R_W
//   - DEFAULT_TIMEOUT_CYCLES: default WAIT limit for the optional timeout
// -----------------------------------------------------------------------------
package lc3_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WWAIT = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5,
    RESP  = 3'd6
  } seq_state_e;

  localparam logic ACCESS_WRITE = 1'b1;
  localparam logic ACCESS_READ  = 1'b0;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for the memory handshake.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr_i     : hold the count at zero (asserted whenever not waiting)
//   en_i      : a wait cycle is in progress
//   expired_o : the current wait cycle is number TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of wait cycles already completed, so the first
  // wait cycle sees 0 and the TIMEOUT_CYCLES-th sees TIMEOUT_CYCLES-1.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_sequencer.sv
// -----------------------------------------------------------------------------
// mem_bus_sequencer
// Upstream master of the LC-3 memory/IO subsystem. Turns one single-word
// read/write request at a time into the LD_MAR / LD_MDR / MIO_EN / R_W /
// GateMDR strobe sequence on the shared BUS, waits for R, and returns the
// result on a valid/ready response channel.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata   : request fields, latched on acceptance
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata, rsp_err            : read data (0 for writes), timeout flag
//   bus_out, bus_oe, bus_in       : BUS drive value / enable, sampled BUS
//   LD_MAR, LD_MDR, MIO_EN, R_W,
//   GateMDR                       : memory subsystem control strobes
//   R                             : access-complete handshake
// Build option: define MEM_BUS_SEQUENCER_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles with rsp_err = 1. Without it WAIT is unbounded and
// rsp_err is tied to 0.
// -----------------------------------------------------------------------------
module mem_bus_sequencer
  import lc3_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic [15:0] bus_in,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        MIO_EN,
  output logic        R_W,
  output logic        GateMDR,
  input  logic        R
);

  seq_state_e  state_q, state_d;
  logic        we_q;
  logic [15:0] addr_q, wdata_q, rdata_q;
  logic        accept;
  logic        waiting;
  logic        timer_expired;
  logic        timeout_hit;

  assign accept  = (state_q == IDLE) && req_valid;
  assign waiting = (state_q == WWAIT) || (state_q == RWAIT);
  // R has priority over the timer when both occur in the same cycle.
  assign timeout_hit = waiting && !R && timer_expired;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    bus_out   = 16'h0000;
    bus_oe    = 1'b0;
    LD_MAR    = 1'b0;
    LD_MDR    = 1'b0;
    MIO_EN    = 1'b0;
    R_W       = ACCESS_READ;
    GateMDR   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ADDR;
      end
      ADDR: begin
        bus_out = addr_q;
        bus_oe  = 1'b1;
        LD_MAR  = 1'b1;
        state_d = (we_q == ACCESS_WRITE) ? WDATA : RWAIT;
      end
      WDATA: begin
        bus_out = wdata_q;
        bus_oe  = 1'b1;
        LD_MDR  = 1'b1;
        state_d = WWAIT;
      end
      WWAIT: begin
        MIO_EN = 1'b1;
        R_W    = ACCESS_WRITE;
        if (R || timeout_hit) state_d = RESP;
      end
      RWAIT: begin
        MIO_EN = 1'b1;
        R_W    = ACCESS_READ;
        LD_MDR = 1'b1;
        if (R) begin
          state_d = RDATA;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RDATA: begin
        // MIO_EN is already low here, so the subsystem starts clearing R
        // while MDR is gated onto the bus.
        GateMDR = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        // Cleared here so writes and aborted reads report 0.
        rdata_q <= 16'h0000;
      end else if (state_q == RDATA) begin
        rdata_q <= bus_in;
      end
    end
  end

  assign rsp_rdata = rdata_q;

`ifdef MEM_BUS_SEQUENCER_TIMEOUT_EN
  logic err_q;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!waiting),
    .en_i     (waiting),
    .expired_o(timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{TIMEOUT_CYCLES, CNT_W};
  assign timer_expired = 1'b0;
  assign rsp_err       = 1'b0;
`endif

endmodule
